// File: rtl/serial_comparator_ctrl.sv
// serial_comparator_ctrl
//   Sequences a 2-bit magnitude-compare slice over WIDTH-bit unsigned operands.
//   The operands are captured on start, and one 2-bit digit pair is compared per
//   clock, most significant pair first. The result is reported as registered
//   one-hot gt/eq/lt flags together with a one-cycle done pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; flags hold the last result (or 0)
//   COMPARE | stepping through digit pairs, busy=1
//   DONE    | one-cycle done pulse; a new start may be accepted here
//
// Parameters
//   WIDTH      operand width in bits, even and >= 2
//   EARLY_EXIT 1: stop at the first unequal pair; 0: always scan every pair
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled in IDLE and DONE only
//   a, b   operands, captured when start is accepted
//   busy   high while in COMPARE
//   done   one-cycle pulse, result valid from this cycle on
//   gt/eq/lt  one-hot compare result (A>B, A==B, A<B)
module serial_comparator_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NPAIR = WIDTH / 2;
    localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPAIR - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             decided;
    logic             dec_gt;

    logic [1:0] pa;
    logic [1:0] pb;
    logic       slice_gt;
    logic       slice_lt;
    logic       slice_eq;

    // Digit-pair select as a decoded mux so the index never goes out of range.
    always_comb begin
        pa = 2'b00;
        pb = 2'b00;
        for (int i = 0; i < NPAIR; i++) begin
            if (idx == IW'(i)) begin
                pa = a_q[2*i +: 2];
                pb = b_q[2*i +: 2];
            end
        end
    end

    assign slice_gt = (pa > pb);
    assign slice_lt = (pa < pb);
    assign slice_eq = (pa == pb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= LAST_IDX;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        idx     <= LAST_IDX;
                        decided <= 1'b0;
                        dec_gt  <= 1'b0;
                        gt      <= 1'b0;
                        eq      <= 1'b0;
                        lt      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_COMPARE;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_COMPARE: begin
                    if (EARLY_EXIT) begin
                        if (!slice_eq) begin
                            gt    <= slice_gt;
                            lt    <= slice_lt;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (idx == '0) begin
                            eq    <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else begin
                        // Constant-time scan: only the first unequal pair counts.
                        if (!decided && !slice_eq) begin
                            decided <= 1'b1;
                            dec_gt  <= slice_gt;
                        end
                        if (idx == '0) begin
                            // The last pair may itself be the deciding one, so
                            // the registered flag is not yet updated here.
                            if (decided) begin
                                gt <= dec_gt;
                                lt <= !dec_gt;
                            end else if (!slice_eq) begin
                                gt <= slice_gt;
                                lt <= slice_lt;
                            end else begin
                                eq <= 1'b1;
                            end
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
module tb_serial_comparator_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel 0: WIDTH=8 early exit, sel 1: WIDTH=8 constant time, sel 2: WIDTH=2 early exit
    logic       st_e, st_c, st_2;
    logic [7:0] a_e, b_e, a_c, b_c;
    logic [1:0] a_2, b_2;
    logic busy_e, done_e, gt_e, eq_e, lt_e;
    logic busy_c, done_c, gt_c, eq_c, lt_c;
    logic busy_2, done_2, gt_2, eq_2, lt_2;

    serial_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst(rst), .start(st_e), .a(a_e), .b(b_e),
        .busy(busy_e), .done(done_e), .gt(gt_e), .eq(eq_e), .lt(lt_e));

    serial_comparator_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(st_c), .a(a_c), .b(b_c),
        .busy(busy_c), .done(done_c), .gt(gt_c), .eq(eq_c), .lt(lt_c));

    serial_comparator_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut_2 (
        .clk(clk), .rst(rst), .start(st_2), .a(a_2), .b(b_2),
        .busy(busy_2), .done(done_2), .gt(gt_2), .eq(eq_2), .lt(lt_2));

    typedef struct {
        logic [2:0] flags;   // {gt, eq, lt}
        int         k;       // done cycle after the accepting edge
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    // {busy, done, gt, eq, lt}
    function automatic logic [4:0] outs(input int sel);
        case (sel)
            1:       return {busy_c, done_c, gt_c, eq_c, lt_c};
            2:       return {busy_2, done_2, gt_2, eq_2, lt_2};
            default: return {busy_e, done_e, gt_e, eq_e, lt_e};
        endcase
    endfunction

    task automatic drive(input int sel, input logic s, input logic [7:0] av, input logic [7:0] bv);
        case (sel)
            1: begin st_c = s; a_c = av; b_c = bv; end
            2: begin st_2 = s; a_2 = av[1:0]; b_2 = bv[1:0]; end
            default: begin st_e = s; a_e = av; b_e = bv; end
        endcase
    endtask

    // One operation: expectation pushed at drive time, popped when done appears.
    // hold=1 keeps start high through COMPARE and returns at the done cycle
    // so the caller can chain the next operation with no idle gap.
    task automatic run_op(input int sel, input logic [7:0] a_in, input logic [7:0] b_in,
                          input bit hold, input string name);
        exp_t       e;
        exp_t       got_e;
        logic [7:0] av, bv;
        logic [4:0] o;
        int         np, cyc;
        bit         got;
        av = (sel == 2) ? (a_in & 8'h03) : a_in;
        bv = (sel == 2) ? (b_in & 8'h03) : b_in;
        np = (sel == 2) ? 1 : 4;
        e.k = np;
        if (sel != 1) begin
            for (int i = np - 1; i >= 0; i--) begin
                if (av[2*i +: 2] != bv[2*i +: 2]) begin
                    e.k = np - i;
                    break;
                end
            end
        end
        e.flags = {av > bv, av == bv, av < bv};
        sb.push_back(e);

        @(negedge clk);
        drive(sel, 1'b1, av, bv);
        @(posedge clk);
        #1;
        drive(sel, hold, ~av, av ^ bv);   // operands change after capture
        cyc = 0;
        got = 0;
        while (!got && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            o = outs(sel);
            n_vec++;
            if (o[3] === 1'b1) begin
                got   = 1;
                got_e = sb.pop_front();
                if (cyc != got_e.k || o[2:0] !== got_e.flags || o[4] !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s: done at cycle %0d flags=%b busy=%b, required cycle %0d flags=%b busy=0",
                             name, cyc, o[2:0], o[4], got_e.k, got_e.flags);
                end
            end else if (o[4] !== 1'b1 || o[2:0] !== 3'b000) begin
                n_err++;
                $display("FAIL %s busy cycle %0d: busy=%b flags=%b, required busy=1 flags=000",
                         name, cyc, o[4], o[2:0]);
            end
        end
        if (!got) begin
            n_err++;
            void'(sb.pop_front());
            $display("FAIL %s timeout: no done within %0d cycles, required cycle %0d", name, cyc, e.k);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            o = outs(sel);
            n_vec++;
            if (o !== {2'b00, e.flags}) begin
                n_err++;
                $display("FAIL %s after done: outs=%b, required %b", name, o, {2'b00, e.flags});
            end
        end
    endtask

    task automatic test_reset;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if (outs(s) !== 5'b00000) begin
                n_err++;
                $display("FAIL reset sel%0d: outs=%b, required 00000", s, outs(s));
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lt_early;
        run_op(0, 8'hB4, 8'hB8, 0, "lt_early_B4_B8");
    endtask

    task automatic test_eq;
        run_op(0, 8'h5A, 8'h5A, 0, "eq_early_5A");
        run_op(1, 8'h5A, 8'h5A, 0, "eq_const_5A");
    endtask

    task automatic test_gt;
        run_op(0, 8'hC0, 8'h3F, 0, "gt_early_C0_3F");
        run_op(1, 8'hC0, 8'h3F, 0, "gt_const_C0_3F");
        run_op(1, 8'h02, 8'h01, 0, "gt_const_lsb");
        run_op(0, 8'h01, 8'h02, 0, "lt_early_lsb");
        run_op(1, 8'h40, 8'h80, 0, "lt_const_msb");
    endtask

    task automatic test_back_to_back;
        run_op(0, 8'h12, 8'h13, 1, "b2b_op1");
        run_op(0, 8'hF0, 8'h0F, 1, "b2b_op2");
        run_op(0, 8'h77, 8'h77, 0, "b2b_op3");
        run_op(1, 8'hAA, 8'hA9, 1, "b2b_const_op1");
        run_op(1, 8'h33, 8'h33, 0, "b2b_const_op2");
    endtask

    task automatic test_random;
        logic [7:0] ra, rb;
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 3 == 0) ? ra ^ 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            run_op(i % 2, ra, rb, 0, "random");
        end
    endtask

    task automatic test_reset_mid;
        logic [4:0] o;
        bit         saw_done;
        @(negedge clk);
        drive(0, 1'b1, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            o = outs(s);
            n_vec++;
            if (o !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_mid sel%0d: outs=%b, required 00000", s, o);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done_e === 1'b1 || busy_e === 1'b1) saw_done = 1;
        end
        n_vec++;
        if (saw_done || outs(0) !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_mid_after: activity=%0d outs=%b, required 0 and 00000",
                     saw_done, outs(0));
        end
    endtask

    task automatic test_exhaustive_w2;
        for (int ia = 0; ia < 4; ia++)
            for (int ib = 0; ib < 4; ib++)
                run_op(2, 8'(ia), 8'(ib), 0, "w2_exhaustive");
    endtask

    initial begin
        drive(0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 8'h00);
        drive(2, 1'b0, 8'h00, 8'h00);
        test_reset;
        test_lt_early;
        test_eq;
        test_gt;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_exhaustive_w2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
